cache_set: RTL

CACHE_SET -- requirements
Module: cache_set

---
 rtl/cache_set.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/cache_set.sv
// One set of a WAYS-way cache: combinational lookup/read, write-hit at the next edge, LRU ages, line refill.
// Refill streams WORDS beats (fill_valid may gap); accesses are ignored while busy, fill_done pulses after the last beat.
module cache_set #(
  parameter int TAG_WIDTH    = 20,
  parameter int OFFSET_WIDTH = 5,
  parameter int WAYS         = 2,
  localparam int WB          = (WAYS > 1) ? $clog2(WAYS) : 1,
  localparam int OW          = OFFSET_WIDTH - 2,
  localparam int WORDS       = 1 << OW
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [TAG_WIDTH-1:0] lookup_tag,
  input  logic [OW-1:0]        offset,
  input  logic                 rd_en,
  input  logic                 wr_en,
  input  logic [3:0]           byte_en,
  input  logic [31:0]          write_data,
  output logic                 hit,
  output logic [WB-1:0]        hit_way,
  output logic [31:0]          read_dataA,
  output logic [31:0]          read_dataB,
  output logic                 cross_line,
  input  logic                 fill_start,
  input  logic [TAG_WIDTH-1:0] fill_tag,
  input  logic                 fill_valid,
  input  logic [31:0]          fill_data,
  output logic                 busy,
  output logic                 fill_done,
  output logic [WB-1:0]        victim_way,
  output logic                 victim_dirty,
  output logic [TAG_WIDTH-1:0] victim_tag
);

  typedef enum logic {IDLE, FILL} state_e;

  state_e                 state_q, state_d;
  logic [OW-1:0]          cnt_q, cnt_d;
  logic [WB-1:0]          tgt_q, tgt_d;
  logic [TAG_WIDTH-1:0]   ftag_q, ftag_d;
  logic                   vdirty_q, vdirty_d;
  logic [TAG_WIDTH-1:0]   vtag_q, vtag_d;
  logic                   fill_done_q, fill_done_d;

  logic [WAYS-1:0]        valid_q;
  logic [WAYS-1:0]        dirty_q;
  logic [TAG_WIDTH-1:0]   tag_q  [WAYS];
  logic [WB-1:0]          age_q  [WAYS];
  logic [31:0]            data_q [WAYS][WORDS];

  logic                   hit_c;
  logic [WB-1:0]          hit_way_c;
  logic [WB-1:0]          vic_c;
  logic                   vic_found;
  logic                   acc_ok, wr_hit, fill_beat, fill_last, lru_en;
  logic [WB-1:0]          lru_way;

  // Downward scans so the lowest matching index wins.
  always_comb begin
    hit_c     = 1'b0;
    hit_way_c = '0;
    if (state_q == IDLE) begin
      for (int w = WAYS - 1; w >= 0; w--) begin
        if (valid_q[w] && (tag_q[w] == lookup_tag)) begin
          hit_c     = 1'b1;
          hit_way_c = WB'(w);
        end
      end
    end
  end

  always_comb begin
    vic_c     = '0;
    vic_found = 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[w]) begin
        vic_c     = WB'(w);
        vic_found = 1'b1;
      end
    end
    if (!vic_found) begin
      for (int w = 0; w < WAYS; w++) begin
        if (age_q[w] == WB'(WAYS - 1)) vic_c = WB'(w);
      end
    end
  end

  assign acc_ok    = (state_q == IDLE) && !fill_start && hit_c;
  assign wr_hit    = acc_ok && wr_en;
  assign fill_beat = (state_q == FILL) && fill_valid;
  assign fill_last = fill_beat && (cnt_q == OW'(WORDS - 1));
  assign lru_en    = (acc_ok && (rd_en || wr_en)) || fill_last;
  assign lru_way   = fill_last ? tgt_q : hit_way_c;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tgt_d       = tgt_q;
    ftag_d      = ftag_q;
    vdirty_d    = vdirty_q;
    vtag_d      = vtag_q;
    fill_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (fill_start) begin
          state_d  = FILL;
          cnt_d    = '0;
          tgt_d    = vic_c;
          ftag_d   = fill_tag;
          vdirty_d = dirty_q[vic_c];
          vtag_d   = tag_q[vic_c];
        end
      end
      FILL: begin
        if (fill_valid) begin
          cnt_d = cnt_q + OW'(1);
          if (cnt_q == OW'(WORDS - 1)) begin
            state_d     = IDLE;
            fill_done_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      tgt_q       <= '0;
      ftag_q      <= '0;
      vdirty_q    <= 1'b0;
      vtag_q      <= '0;
      fill_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tgt_q       <= tgt_d;
      ftag_q      <= ftag_d;
      vdirty_q    <= vdirty_d;
      vtag_q      <= vtag_d;
      fill_done_q <= fill_done_d;
    end
  end

  // Line storage; a fill invalidates its target on entry so an aborted fill never exposes a partial line.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      dirty_q <= '0;
      for (int w = 0; w < WAYS; w++) begin
        tag_q[w] <= '0;
        age_q[w] <= WB'(w);
        for (int k = 0; k < WORDS; k++) data_q[w][k] <= '0;
      end
    end else begin
      if ((state_q == IDLE) && fill_start) begin
        valid_q[vic_c] <= 1'b0;
        dirty_q[vic_c] <= 1'b0;
      end
      if (wr_hit) begin
        for (int b = 0; b < 4; b++) begin
          if (byte_en[b]) data_q[hit_way_c][offset][8*b +: 8] <= write_data[8*b +: 8];
        end
        dirty_q[hit_way_c] <= 1'b1;
      end
      if (fill_beat) data_q[tgt_q][cnt_q] <= fill_data;
      if (fill_last) begin
        tag_q[tgt_q]   <= ftag_q;
        valid_q[tgt_q] <= 1'b1;
        dirty_q[tgt_q] <= 1'b0;
      end
      if (lru_en) begin
        for (int w = 0; w < WAYS; w++) begin
          if (WB'(w) == lru_way)            age_q[w] <= '0;
          else if (age_q[w] < age_q[lru_way]) age_q[w] <= age_q[w] + WB'(1);
        end
      end
    end
  end

  assign hit          = hit_c;
  assign hit_way      = hit_way_c;
  assign cross_line   = (offset == OW'(WORDS - 1));
  assign read_dataA   = hit_c ? data_q[hit_way_c][offset] : 32'h0;
  assign read_dataB   = (hit_c && !cross_line) ? data_q[hit_way_c][offset + OW'(1)] : 32'h0;
  assign busy         = (state_q == FILL);
  assign fill_done    = fill_done_q;
  assign victim_way   = busy ? tgt_q    : vic_c;
  assign victim_dirty = busy ? vdirty_q : dirty_q[vic_c];
  assign victim_tag   = busy ? vtag_q   : tag_q[vic_c];

endmodule
